multi_port_ram: RTL and testbench

Parametrised successor to the fixed 32-bit, 256-word, two-read/one-write RAM. It provides `NUM_RD` independent registered read ports and one byte-enabled write port. Same-address write-to-read bypass is selectable, and a hardware clear sequencer zeroes the array after reset or on request. It sits beside the datapath as a general register file / scratch memory and reports availability on `ready`.

---
 rtl/multi_port_ram.sv | 103 ++++++++++
 tb/tb_multi_port_ram.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_port_ram.sv
// Multi-port register file: NUM_RD registered read ports, one byte-enabled write port,
// optional same-address write-to-read bypass, and a hardware clear sweep after reset or clr.
module multi_port_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [ADDR_W-1:0]        addr_wr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_addr, clr_addr_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word [NUM_RD];
  logic [DATA_W-1:0] rd_q [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q;
  logic              accept;

  // Handshake: re/we are taken on an edge only when ready was high before it and clr is low;
  // rd_valid[p] pulses for exactly the cycle after an accepted read on port p.
  assign ready  = (state == RUN);
  assign accept = ready && !clr;

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    if (clr) begin
      state_next    = INIT;
      clr_addr_next = '0;
    end else if (state == INIT) begin
      clr_addr_next = clr_addr + ADDR_W'(1);
      if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // The array has no reset; the INIT sweep zeroes it one word per edge.
  always_ff @(posedge clk) begin
    if (state == INIT && !clr) begin
      mem[clr_addr] <= '0;
    end else if (accept && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr_wr][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
      if (BYPASS != 0 && we && rd_addr[p*ADDR_W +: ADDR_W] == addr_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) rd_word[p][8*i +: 8] = data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_RD; p++) rd_q[p] <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_valid_q[p] <= accept && re[p];
        if (accept && re[p]) rd_q[p] <= rd_word[p];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rd_data[g*DATA_W +: DATA_W] = rd_q[g];
  end

  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_multi_port_ram.sv
// Bench for multi_port_ram: bypass and non-bypass instances share stimulus; a scoreboard
// queue per instance is filled by the driver and drained by a monitor on rd_valid.
module tb_multi_port_ram;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int DEPTH = 16;
  localparam int BW    = DW / 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic           we = 1'b0;
  logic [BW-1:0]  be = '0;
  logic [AW-1:0]  addr_wr = '0;
  logic [DW-1:0]  data_in = '0;
  logic [NR-1:0]  re = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_valid_b, rd_valid_n;
  logic             ready_b, ready_n;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_qb[$];
  logic [DW-1:0] exp_qn[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic          model_ready;
  int            ready_cnt;

  always #5 clk = ~clk;

  multi_port_ram #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .be(be), .addr_wr(addr_wr),
    .data_in(data_in), .re(re), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .ready(ready_b)
  );

  multi_port_ram #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .be(be), .addr_wr(addr_wr),
    .data_in(data_in), .re(re), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_valid(rd_valid_n), .ready(ready_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole array reads as zero from the model's point of view; ready after DEPTH edges.
  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    model_ready = 1'b0;
    ready_cnt   = DEPTH;
  endtask

  task automatic cycle(input logic c, input logic w, input logic [BW-1:0] b,
                       input logic [AW-1:0] aw, input logic [DW-1:0] d,
                       input logic [NR-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [DW-1:0] merged, old;
    logic [AW-1:0] ra;
    clr = c; we = w; be = b; addr_wr = aw; data_in = d; re = r; rd_addr = {a1, a0};
    if (model_ready && !c) begin
      merged = model_mem[aw];
      for (int i = 0; i < BW; i++) if (b[i]) merged[8*i +: 8] = d[8*i +: 8];
      for (int p = 0; p < NR; p++) begin
        ra = (p == 0) ? a0 : a1;
        if (r[p]) begin
          old = model_mem[ra];
          exp_qn.push_back(old);
          exp_qb.push_back((w && ra == aw) ? merged : old);
        end
      end
      if (w) model_mem[aw] = merged;
    end
    @(posedge clk);
    if (c) begin
      model_clear();
    end else if (!model_ready) begin
      ready_cnt--;
      if (ready_cnt == 0) model_ready = 1'b1;
    end
    #1;
    check("ready_b", 64'(ready_b), 64'(model_ready));
    check("ready_n", 64'(ready_n), 64'(model_ready));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data_b"}, rd_data_b, 64'd0);
    check({tag, "_rd_data_n"}, rd_data_n, 64'd0);
    check({tag, "_rd_valid"}, 64'({rd_valid_b, rd_valid_n}), 64'd0);
    check({tag, "_ready"}, 64'({ready_b, ready_n}), 64'd0);
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NR; p++) begin
      if (rd_valid_b[p]) begin
        if (exp_qb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid_b port %0d data %0h", p, rd_data_b[p*DW +: DW]);
        end else check($sformatf("rd_data_b[%0d]", p), 64'(rd_data_b[p*DW +: DW]), 64'(exp_qb.pop_front()));
      end
      if (rd_valid_n[p]) begin
        if (exp_qn.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid_n port %0d data %0h", p, rd_data_n[p*DW +: DW]);
        end else check($sformatf("rd_data_n[%0d]", p), 64'(rd_data_n[p*DW +: DW]), 64'(exp_qn.pop_front()));
      end
    end
  end

  initial begin
    model_clear();
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    check_reset_outputs("por_held");
    rst_n = 1'b1;
    model_clear();

    // Init sweep: ready low for 15 edges, high after the 16th.
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, AW'(a), AW'(a));
    idle(1);

    // Basic write/read; the trailing idle catches a rd_valid lasting more than one cycle.
    cycle(1'b0, 1'b1, 4'hF, 4'd1, 32'hA5A5A5A5, 2'b00, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, 4'd1, 4'd1);
    idle(2);

    // Byte enables, including a be=0 no-op write.
    cycle(1'b0, 1'b1, 4'hF, 4'd0, 32'hFFFFFFFF, 2'b00, '0, '0);
    cycle(1'b0, 1'b1, 4'b0101, 4'd0, 32'h12345678, 2'b00, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'b01, 4'd0, '0);
    cycle(1'b0, 1'b1, 4'b0000, 4'd0, 32'h0BADF00D, 2'b10, '0, 4'd0);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, 4'd0, 4'd0);

    // Collision on addr 2: bypass vs pre-write contents, write lands either way.
    cycle(1'b0, 1'b1, 4'hF, 4'd2, 32'h11111111, 2'b00, '0, '0);
    cycle(1'b0, 1'b1, 4'b0011, 4'd2, 32'hAAAABBBB, 2'b11, 4'd2, 4'd0);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, 4'd2, 4'd2);

    // clr in RUN: same-cycle write/read ignored, array zeroed after DEPTH edges.
    cycle(1'b0, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 2'b00, '0, '0);
    cycle(1'b1, 1'b1, 4'hF, 4'd5, 32'hCAFEF00D, 2'b11, 4'd3, 4'd5);
    idle(DEPTH);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, 4'd3, 4'd5);

    // clr during INIT restarts the sweep.
    cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
    idle(5);
    cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
    idle(DEPTH);

    // Randomized traffic with occasional clr.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), BW'($urandom_range(0, 15)),
            AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), NR'($urandom_range(0, 3)),
            AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
    end
    idle(DEPTH);

    // Async reset between edges while rd_data holds A5A5A5A5.
    cycle(1'b0, 1'b1, 4'hF, 4'd7, 32'hA5A5A5A5, 2'b00, '0, '0);
    cycle(1'b0, 1'b1, 4'hF, 4'd9, 32'h5A5A5A5A, 2'b00, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, 4'd7, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    #1 rst_n = 1'b1;
    model_clear();
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, '0, '0, '0, 2'b11, AW'(a), AW'(DEPTH - 1 - a));
    idle(2);

    total++;
    if (exp_qb.size() != 0 || exp_qn.size() != 0) begin
      bad++;
      $display("FAIL pending_reads: got %0d/%0d left expected 0/0", exp_qb.size(), exp_qn.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
